// File: rtl/div_freq_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable generator.
// Integrators use hz_to_half() to turn a target output frequency into div_val.
package div_freq_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_HALF_1K = 25000;

  // Half-period in input cycles for an output of 'hz'; 0 Hz maps to 0, which
  // the channel stores as 1.
  function automatic int unsigned hz_to_half(input int unsigned hz);
    return (hz == 0) ? 0 : CLK_HZ / (2 * hz);
  endfunction

endpackage

// File: rtl/div_freq_chan.sv
// One divider channel: programmable half-period, counter, square wave and
// a one-cycle tick on each rising edge of the square wave.
module div_freq_chan
  import div_freq_pkg::*;
#(
  parameter int          CNT_W    = 26,
  parameter int unsigned DEF_HALF = DEF_HALF_1K
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick
);

  // A zero half-period would never reach terminal count; clamp to 1.
  localparam logic [CNT_W-1:0] HALF_RST = (DEF_HALF == 0) ? CNT_W'(1) : CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wr_half;
  logic             terminal;

  assign wr_half  = (div_val == '0) ? CNT_W'(1) : div_val;
  assign terminal = (cnt == (half - CNT_W'(1)));

  // A write takes priority over terminal count: the new half-period is timed
  // from a fresh count and the output level is left alone.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      half    <= HALF_RST;
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wr) begin
      half    <= wr_half;
      cnt     <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= ~clk_out;
      end else begin
        cnt     <= cnt + CNT_W'(1);
        tick    <= 1'b0;
      end
    end else begin
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/div_freq_multi.sv
// NUM_CH independent clock-enable channels driven from clk_50M, each with a
// runtime-programmable half-period written through a single strobe port.
module div_freq_multi
  import div_freq_pkg::*;
#(
  parameter  int          NUM_CH   = 4,
  parameter  int          CNT_W    = 26,
  parameter  int unsigned DEF_HALF = DEF_HALF_1K,
  localparam int          SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              en,
  input  logic              div_we,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  // Write port: div_we is a single-cycle strobe with no back-pressure; a write
  // is taken in the cycle it is presented, and an out-of-range div_sel simply
  // decodes to no channel.
  logic [NUM_CH-1:0] wr;

  always_comb begin
    wr = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      wr[k] = div_we && (32'(div_sel) == 32'(k));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    div_freq_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .en      (en),
      .wr      (wr[g]),
      .div_val (div_val),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_div_freq_multi.sv
// Directed bench for div_freq_multi (NUM_CH=2, CNT_W=8, DEF_HALF=3) plus a
// 3-channel instance used to exercise an out-of-range channel select.
module tb_div_freq_multi;

  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic             en      = 1'b1;
  logic             div_we  = 1'b0;
  logic             div_sel = 1'b0;
  logic [CNT_W-1:0] div_val = '0;
  logic [1:0]       clk_out;
  logic [1:0]       tick;

  logic             div_we3  = 1'b0;
  logic [1:0]       div_sel3 = 2'd0;
  logic [2:0]       clk_out3;
  logic [2:0]       tick3;

  div_freq_multi #(.NUM_CH(2), .CNT_W(CNT_W), .DEF_HALF(3)) u_dut (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .en      (en),
    .div_we  (div_we),
    .div_sel (div_sel),
    .div_val (div_val),
    .clk_out (clk_out),
    .tick    (tick)
  );

  div_freq_multi #(.NUM_CH(3), .CNT_W(CNT_W), .DEF_HALF(3)) u_dut3 (
    .clk_50M (clk_50M),
    .rst_n   (rst_n),
    .en      (en),
    .div_we  (div_we3),
    .div_sel (div_sel3),
    .div_val (div_val),
    .clk_out (clk_out3),
    .tick    (tick3)
  );

  // ---------------- scoreboard ----------------
  // Each entry is {tick[1], tick[0], clk_out[1], clk_out[0]} for one cycle.
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       chk3   = 1'b0;

  task automatic check(input string tag, input int idx,
                       input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp_v);
    end
  endtask

  // Samples one negedge per queued entry; the 3-channel instance, when
  // enabled, must track channel 0 of the main instance on every channel.
  task automatic drain(input string tag);
    logic [3:0] exp_v;
    int         idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      @(negedge clk_50M);
      check(tag, idx, {4'b0, tick, clk_out}, {4'b0, exp_v});
      if (chk3)
        check({tag, "_ch3"}, idx, {2'b0, tick3, clk_out3},
              {2'b0, {3{exp_v[2]}}, {3{exp_v[0]}}});
      idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_half(input logic sel, input logic [CNT_W-1:0] val);
    div_we  = 1'b1;
    div_sel = sel;
    div_val = val;
    @(posedge clk_50M);
    #1 div_we = 1'b0;
  endtask

  task automatic write_half3(input logic [1:0] sel, input logic [CNT_W-1:0] val);
    div_we3  = 1'b1;
    div_sel3 = sel;
    div_val  = val;
    @(posedge clk_50M);
    #1 div_we3 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    @(negedge clk_50M);
    @(negedge clk_50M);
    check("reset", 0, {4'b0, tick, clk_out}, 8'h00);
    check("reset3", 0, {2'b0, tick3, clk_out3}, 8'h00);
    rst_n = 1'b1;

    // 1: half=3 on both channels, first rise + tick 3 cycles after release.
    //    An out-of-range write on the 3-channel instance must not disturb it.
    chk3  = 1'b1;
    exp_q = '{4'b0000, 4'b0000, 4'b1111, 4'b0011};
    drain("t1_run");
    write_half3(2'd3, 8'd1);
    exp_q = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    drain("t1_sel_oor");
    chk3  = 1'b0;

    // 2: ch1 half=5 written one cycle after its rise; level holds, toggles
    //    5 cycles later; ch0 keeps period 6.
    write_half(1'b1, 8'd5);
    exp_q = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0101,
              4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b0111};
    drain("t2_half5");

    // 3: ch0 div_val=0 stored as 1 -> toggles every cycle, tick every 2.
    write_half(1'b0, 8'd0);
    exp_q = '{4'b0011, 4'b0010, 4'b0111, 4'b0000, 4'b0101};
    drain("t3_half1");

    // 4: ch0 back to half=3, one counted cycle, then en low for 7 cycles.
    write_half(1'b0, 8'd3);
    exp_q = '{4'b0001, 4'b0001};
    drain("t4_pre");
    en    = 1'b0;
    exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    drain("t4_frozen");
    en    = 1'b1;
    exp_q = '{4'b0001, 4'b1010};
    drain("t4_resume");

    // 5: write ch1 (half=2) exactly when cnt[1]==4 -> no toggle, no tick,
    //    then a fresh 2-cycle half-period.
    exp_q = '{4'b0010, 4'b0010, 4'b0111, 4'b0011};
    drain("t5_pre");
    write_half(1'b1, 8'd2);
    exp_q = '{4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'b1111};
    drain("t5_collide");

    // 6: asynchronous reset mid-period, then default half=3 on both channels.
    exp_q = '{4'b0011};
    drain("t6_pre");
    #2 rst_n = 1'b0;
    #1 check("t6_async", 0, {4'b0, tick, clk_out}, 8'h00);
    @(negedge clk_50M);
    check("t6_held", 0, {4'b0, tick, clk_out}, 8'h00);
    rst_n = 1'b1;
    exp_q = '{4'b0000, 4'b0000, 4'b1111, 4'b0011, 4'b0011, 4'b0000};
    drain("t6_restart");

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
